// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: instruction-decode stage for the MUSA core.
// Holds the register file, extracts instruction fields, sign-extends the
// immediate and forms the jump target. Upstream is a valid/ready handshake,
// downstream is a registered ID/EX slot with stall and flush. A load-use
// hazard detector inserts one bubble.
//
// Optional feature macro: DECODE_WB_BYPASS_EN
//   defined   -> register reads see a same-cycle write-back (write-first)
//   undefined -> register reads return the pre-write value
module decode_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_jump_target,
    output logic [DATA_W-1:0] ex_pc,
    output logic [4:0]        ex_dst,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_func,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_is_branch,
    output logic              ex_is_jump,
    output logic              hazard_stall
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] jump_target;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wb_writes;

    logic              dec_reg_write;
    logic              dec_mem_read;
    logic              dec_mem_write;
    logic              dec_is_branch;
    logic              dec_is_jump;
    logic              uses_rt;
    logic [4:0]        dec_dst;

    assign opcode      = in_instr[31:26];
    assign func        = in_instr[5:0];
    assign rs_addr     = in_instr[25:21];
    assign rt_addr     = in_instr[20:16];
    assign rd_addr     = in_instr[15:11];
    assign imm_ext     = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    assign jump_target = {{(DATA_W-28){1'b0}}, in_instr[25:0], 2'b00};

    // Register 0 and out-of-range addresses are never written.
    assign wb_writes = wb_en && (wb_addr != 5'd0) && (int'(wb_addr) < NUM_REGS);

    // Register file write port; reset clears every architectural register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_writes) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Two read ports; register 0 and addresses beyond NUM_REGS read as zero.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if ((rs_addr != 5'd0) && (int'(rs_addr) < NUM_REGS)) begin
            rs_data = regs[rs_addr];
        end
        if ((rt_addr != 5'd0) && (int'(rt_addr) < NUM_REGS)) begin
            rt_data = regs[rt_addr];
        end
`ifdef DECODE_WB_BYPASS_EN
        if (wb_writes && (wb_addr == rs_addr)) begin
            rs_data = wb_data;
        end
        if (wb_writes && (wb_addr == rt_addr)) begin
            rt_data = wb_data;
        end
`endif
    end

    // Opcode decode into control bits, destination and rt usage.
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_is_branch = 1'b0;
        dec_is_jump   = 1'b0;
        uses_rt       = 1'b0;
        dec_dst       = rt_addr;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_dst       = rd_addr;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                dec_is_branch = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADDI, OP_ORI: begin
                dec_reg_write = 1'b1;
            end
            OP_J: begin
                dec_is_jump = 1'b1;
            end
            OP_JAL: begin
                dec_is_jump   = 1'b1;
                dec_reg_write = 1'b1;
                dec_dst       = 5'd31;
            end
            default: begin
            end
        endcase
    end

    // A load in EX whose destination feeds this instruction must wait a cycle.
    assign hazard_stall = in_valid && ex_valid && ex_mem_read && (ex_dst != 5'd0) &&
                          ((ex_dst == rs_addr) || (uses_rt && (ex_dst == rt_addr)));

    assign in_ready = !ex_stall && !hazard_stall && !flush;

    // ID/EX register: flush beats stall, stall holds, otherwise capture or bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid       <= 1'b0;
            ex_rs_data     <= '0;
            ex_rt_data     <= '0;
            ex_imm         <= '0;
            ex_jump_target <= '0;
            ex_pc          <= '0;
            ex_dst         <= '0;
            ex_opcode      <= '0;
            ex_func        <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_is_branch   <= 1'b0;
            ex_is_jump     <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_stall) begin
            ex_valid <= ex_valid;
        end else if (hazard_stall || !in_valid) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid       <= 1'b1;
            ex_rs_data     <= rs_data;
            ex_rt_data     <= rt_data;
            ex_imm         <= imm_ext;
            ex_jump_target <= jump_target;
            ex_pc          <= in_pc;
            ex_dst         <= dec_dst;
            ex_opcode      <= opcode;
            ex_func        <= func;
            ex_reg_write   <= dec_reg_write;
            ex_mem_read    <= dec_mem_read;
            ex_mem_write   <= dec_mem_write;
            ex_is_branch   <= dec_is_branch;
            ex_is_jump     <= dec_is_jump;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Testbench for decode_stage_pipe: table-driven vectors through a
// scoreboard queue, plus hand-written hazard, stall, flush, bypass and
// reset sequences.
module tb_decode_stage_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_jump_target;
    logic [31:0] ex_pc;
    logic [4:0]  ex_dst;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_func;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        hazard_stall;

    decode_stage_pipe #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_jump_target(ex_jump_target), .ex_pc(ex_pc),
        .ex_dst(ex_dst), .ex_opcode(ex_opcode), .ex_func(ex_func),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .hazard_stall(hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  ctrl;
        logic [4:0]  dst;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [4:0]  dst;
        logic [4:0]  ctrl;
    } exp_t;

    exp_t        expq [$];
    exp_t        last_rec;
    logic        last_valid;
    logic [31:0] model_regs [32];
    logic [31:0] pc_cnt;
    int          tests_run;
    int          tests_failed;
    vec_t        vecs [11];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model register read as seen by an instruction in the current cycle.
    function automatic logic [31:0] modelRead(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'h0 : model_regs[a];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (wb_addr == a) && (a != 5'd0)) v = wb_data;
`endif
        return v;
    endfunction

    // One cycle: drive at negedge, check handshake, then check the EX slot.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [4:0] ctrl,
                                 input logic [4:0] dst, input logic exp_ready, input logic exp_hazard);
        exp_t rec;
        in_valid = v;
        in_instr = instr;
        in_pc    = pc_cnt;
        #1;
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        checkOutput("hazard_stall", {31'b0, hazard_stall}, {31'b0, exp_hazard});
        if (v && exp_ready) begin
            rec.instr   = instr;
            rec.pc      = pc_cnt;
            rec.rs_data = modelRead(instr[25:21]);
            rec.rt_data = modelRead(instr[20:16]);
            rec.imm     = {{16{instr[15]}}, instr[15:0]};
            rec.jt      = {4'b0, instr[25:0], 2'b00};
            rec.dst     = dst;
            rec.ctrl    = ctrl;
            expq.push_back(rec);
        end
        @(posedge clk);
        if (wb_en && (wb_addr != 5'd0)) model_regs[wb_addr] = wb_data;
        @(negedge clk);
        if (flush) begin
            last_valid = 1'b0;
        end else if (ex_stall) begin
            last_valid = last_valid;
        end else if (expq.size() > 0) begin
            last_rec   = expq.pop_front();
            last_valid = 1'b1;
        end else begin
            last_valid = 1'b0;
        end
        checkOutput("ex_valid", {31'b0, ex_valid}, {31'b0, last_valid});
        if (last_valid) begin
            checkOutput("ex_rs_data", ex_rs_data, last_rec.rs_data);
            checkOutput("ex_rt_data", ex_rt_data, last_rec.rt_data);
            checkOutput("ex_imm", ex_imm, last_rec.imm);
            checkOutput("ex_jump_target", ex_jump_target, last_rec.jt);
            checkOutput("ex_pc", ex_pc, last_rec.pc);
            checkOutput("ex_dst", {27'b0, ex_dst}, {27'b0, last_rec.dst});
            checkOutput("ex_opcode", {26'b0, ex_opcode}, {26'b0, last_rec.instr[31:26]});
            checkOutput("ex_func", {26'b0, ex_func}, {26'b0, last_rec.instr[5:0]});
            checkOutput("ex_ctrl",
                        {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump},
                        {27'b0, last_rec.ctrl});
        end
        pc_cnt = pc_cnt + 32'd4;
    endtask

    task automatic wbWrite(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        applyStimulus(1'b0, 32'h0, 5'b0, 5'b0, 1'b1, 1'b0);
        wb_en   = 1'b0;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        last_valid   = 1'b0;
        pc_cnt       = 32'h0000_1000;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;

        // ctrl = {reg_write, mem_read, mem_write, is_branch, is_jump}
        vecs[0]  = '{rtype(5'd5, 5'd0, 5'd7, 6'h20),          5'b10000, 5'd7};
        vecs[1]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h22),          5'b10000, 5'd3};
        vecs[2]  = '{itype(6'h23, 5'd1, 5'd10, 16'h0004),     5'b11000, 5'd10};
        vecs[3]  = '{itype(6'h2B, 5'd2, 5'd9, 16'hFFF0),      5'b00100, 5'd9};
        vecs[4]  = '{itype(6'h04, 5'd1, 5'd5, 16'h8000),      5'b00010, 5'd5};
        vecs[5]  = '{itype(6'h08, 5'd9, 5'd4, 16'hFFFE),      5'b10000, 5'd4};
        vecs[6]  = '{itype(6'h0D, 5'd0, 5'd6, 16'h7FFF),      5'b10000, 5'd6};
        vecs[7]  = '{jtype(6'h02, 26'h0100000),               5'b00001, 5'd16};
        vecs[8]  = '{jtype(6'h03, 26'h3FFFFFF),               5'b10001, 5'd31};
        vecs[9]  = '{itype(6'h3F, 5'd1, 5'd12, 16'h1234),     5'b00000, 5'd12};
        vecs[10] = '{rtype(5'd9, 5'd9, 5'd0, 6'h25),          5'b10000, 5'd0};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'h0;
        in_pc    = 32'h0;
        wb_en    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'h0;
        ex_stall = 1'b0;
        flush    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("reset_ex_rs_data", ex_rs_data, 32'h0);
        checkOutput("reset_ex_pc", ex_pc, 32'h0);
        checkOutput("reset_ex_ctrl",
                    {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h1);

        // Register file contents; the write to register 0 must be dropped
        wbWrite(5'd1, 32'h0000_0011);
        wbWrite(5'd2, 32'h0000_0022);
        wbWrite(5'd5, 32'h0000_1234);
        wbWrite(5'd9, 32'hDEAD_BEEF);
        wbWrite(5'd0, 32'hFFFF_FFFF);

        // Decode table vectors
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].instr, vecs[i].ctrl, vecs[i].dst, 1'b1, 1'b0);
        end

        // Explicit boundary constants
        applyStimulus(1'b1, jtype(6'h02, 26'h0100000), 5'b00001, 5'd16, 1'b1, 1'b0);
        checkOutput("j_target_const", ex_jump_target, 32'h0040_0000);
        checkOutput("j_is_jump_const", {31'b0, ex_is_jump}, 32'h1);
        applyStimulus(1'b1, itype(6'h08, 5'd1, 5'd4, 16'hFFFE), 5'b10000, 5'd4, 1'b1, 1'b0);
        checkOutput("addi_imm_const", ex_imm, 32'hFFFF_FFFE);
        applyStimulus(1'b1, rtype(5'd0, 5'd5, 5'd7, 6'h20), 5'b10000, 5'd7, 1'b1, 1'b0);
        checkOutput("reg0_reads_zero", ex_rs_data, 32'h0);
        checkOutput("rt5_value", ex_rt_data, 32'h0000_1234);

        // Load-use on rs: exactly one bubble, then the held ADD goes through
        applyStimulus(1'b1, itype(6'h23, 5'd0, 5'd8, 16'h0000), 5'b11000, 5'd8, 1'b1, 1'b0);
        applyStimulus(1'b1, rtype(5'd8, 5'd0, 5'd11, 6'h20), 5'b10000, 5'd11, 1'b0, 1'b1);
        applyStimulus(1'b1, rtype(5'd8, 5'd0, 5'd11, 6'h20), 5'b10000, 5'd11, 1'b1, 1'b0);
        // Load-use through rt of a store
        applyStimulus(1'b1, itype(6'h23, 5'd0, 5'd8, 16'h0000), 5'b11000, 5'd8, 1'b1, 1'b0);
        applyStimulus(1'b1, itype(6'h2B, 5'd0, 5'd8, 16'h0008), 5'b00100, 5'd8, 1'b0, 1'b1);
        applyStimulus(1'b1, itype(6'h2B, 5'd0, 5'd8, 16'h0008), 5'b00100, 5'd8, 1'b1, 1'b0);
        // ADDI only reads rs, so an rt match is no hazard
        applyStimulus(1'b1, itype(6'h23, 5'd0, 5'd8, 16'h0000), 5'b11000, 5'd8, 1'b1, 1'b0);
        applyStimulus(1'b1, itype(6'h08, 5'd1, 5'd8, 16'h0001), 5'b10000, 5'd8, 1'b1, 1'b0);
        // Load into register 0 never stalls
        applyStimulus(1'b1, itype(6'h23, 5'd0, 5'd0, 16'h0000), 5'b11000, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, rtype(5'd0, 5'd0, 5'd12, 6'h20), 5'b10000, 5'd12, 1'b1, 1'b0);

        // EX stall held three cycles, then flush during the stall
        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd13, 6'h20), 5'b10000, 5'd13, 1'b1, 1'b0);
        ex_stall = 1'b1;
        repeat (3) applyStimulus(1'b1, rtype(5'd9, 5'd5, 5'd14, 6'h21), 5'b10000, 5'd14, 1'b0, 1'b0);
        flush = 1'b1;
        applyStimulus(1'b1, rtype(5'd9, 5'd5, 5'd14, 6'h21), 5'b10000, 5'd14, 1'b0, 1'b0);
        flush    = 1'b0;
        ex_stall = 1'b0;
        applyStimulus(1'b1, rtype(5'd9, 5'd5, 5'd14, 6'h21), 5'b10000, 5'd14, 1'b1, 1'b0);
        // Flush alone kills the incoming instruction
        flush = 1'b1;
        applyStimulus(1'b1, rtype(5'd2, 5'd1, 5'd15, 6'h20), 5'b10000, 5'd15, 1'b0, 1'b0);
        flush = 1'b0;

        // Same-cycle write-back and read of register 3
        wb_en   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hAAAA_5555;
        applyStimulus(1'b1, rtype(5'd3, 5'd0, 5'd4, 6'h20), 5'b10000, 5'd4, 1'b1, 1'b0);
        wb_en   = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        checkOutput("bypass_rs_const", ex_rs_data, 32'hAAAA_5555);
`else
        checkOutput("bypass_rs_const", ex_rs_data, 32'h0);
`endif
        applyStimulus(1'b1, rtype(5'd3, 5'd0, 5'd4, 6'h20), 5'b10000, 5'd4, 1'b1, 1'b0);
        checkOutput("r3_next_cycle", ex_rs_data, 32'hAAAA_5555);

        // Reset in the middle of a stall discards everything
        applyStimulus(1'b1, rtype(5'd5, 5'd9, 5'd16, 6'h20), 5'b10000, 5'd16, 1'b1, 1'b0);
        ex_stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset_ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("midreset_ex_rs_data", ex_rs_data, 32'h0);
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        last_valid = 1'b0;
        expq.delete();
        @(negedge clk);
        rst      = 1'b1;
        ex_stall = 1'b0;
        applyStimulus(1'b1, rtype(5'd5, 5'd9, 5'd7, 6'h20), 5'b10000, 5'd7, 1'b1, 1'b0);
        checkOutput("midreset_regs_cleared", ex_rs_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
